// File: rtl/iterative_shifter.sv
// Iterative 32-bit shifter: SLL / SRL / SRA / ROTR, one bit position per clock.
// Three-state FSM (IDLE -> SHIFT -> DONE) with registered Ready/Busy/Done.
module iterative_shifter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] Data,
    input  logic [31:0] ShAmt,
    output logic [31:0] Result,
    output logic        Ready,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_result;
    logic [4:0]  r_count;
    op_t         r_op;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic [31:0] w_shifted;
    logic        w_ready_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    // Only the low five bits select the amount; the upper bits are
    // deliberately dropped with no flag raised.
    logic        w_unused_shamt;
    assign w_unused_shamt = ^ShAmt[31:5];

    // State register. Reset is synchronous and outranks everything else,
    // so an aborted shift never reaches DONE.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before the edge, regardless of block order.
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // w_state_nxt unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt = (ShAmt[4:0] != 5'd0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_count == 5'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state, registered below so the status
    // outputs are flops with no combinational path from the inputs.
    always_comb begin
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt == S_SHIFT);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // One-bit step of the latched operation.
    always_comb begin
        w_shifted = r_result;
        unique case (r_op)
            OP_SLL:  w_shifted = {r_result[30:0], 1'b0};
            OP_SRL:  w_shifted = {1'b0, r_result[31:1]};
            OP_SRA:  w_shifted = {r_result[31], r_result[31:1]};
            OP_ROTR: w_shifted = {r_result[0], r_result[31:1]};
            default: w_shifted = r_result;
        endcase
    end

    // Datapath: capture on an accepted Start, step once per SHIFT cycle,
    // otherwise hold so Result stays valid from DONE until the next Start.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_result <= 32'h0000_0000;
            r_count  <= 5'd0;
            r_op     <= OP_SLL;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_result <= Data;
                        r_count  <= ShAmt[4:0];
                        r_op     <= op_t'(Op);
                    end
                end
                S_SHIFT: begin
                    r_result <= w_shifted;
                    r_count  <= r_count - 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign Result = r_result;
    assign Ready  = r_ready;
    assign Busy   = r_busy;
    assign Done   = r_done;

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 Clock and reset SHALL be one clock, `Clk`, and one synchronous, active-low reset, `Reset`. Reset is sampled only on the rising edge of `Clk`.
REQ-002 Ports SHALL be:
- `Clk`  input  1  rising-edge clock.
- `Reset`  input  1  synchronous active-low reset.
- `Start`  input  1  request a shift; sampled only when `Ready`=1.
- `Op`  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- `Data`  input  32  operand to shift.
- `ShAmt`  input  32  zero-extended shift amount from the shamt extension stage; only bits [4:0] are used.
- `Result`  output  32  shifted value.
- `Ready`  output  1  block is idle and accepts `Start`.
- `Busy`  output  1  shift in progress.
- `Done`  output  1  one-cycle pulse; `Result` is valid.

Function
REQ-003 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-004 In IDLE, when `Start`=1 on an edge, the block SHALL:
- capture `Data` into `Result`, `Op` into an op register, and `ShAmt`[4:0] into a 5-bit count;
- go to SHIFT if `ShAmt`[4:0]≠0, else go to DONE.
REQ-005 `ShAmt`[31:5] SHALL be ignored; no error or flag is raised for nonzero upper bits.
REQ-006 In SHIFT, each edge SHALL shift `Result` by exactly one bit per the latched op and decrement the count by 1:
- SLL: shift in 0 at bit 0.
- SRL: shift in 0 at bit 31.
- SRA: shift in the current `Result`[31].
- ROTR: old bit 0 moves to bit 31.
REQ-007 In SHIFT, when the count is 1 before the edge, that edge SHALL perform the final shift and go to DONE.
REQ-008 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-009 Latency: with N=`ShAmt`[4:0], `Done` SHALL be high in the cycle N+1 edges after the edge that sampled `Start` (N=0 gives 1 cycle; N=31 gives 32 cycles).
REQ-010 Outputs SHALL be decoded from state:
- `Ready`=1 only in IDLE.
- `Busy`=1 only in SHIFT.
- `Done`=1 only in DONE.
- Exactly one of the three is high in any cycle.
REQ-011 Input stability: `Start`, `Data`, `Op` and `ShAmt` SHALL be ignored in SHIFT and DONE. Changes to them mid-operation SHALL NOT affect the result.
REQ-012 `Result` SHALL hold its value from DONE through IDLE until the next accepted `Start`.
REQ-013 Back-to-back operation: `Start` held high SHALL be accepted in the IDLE cycle that follows DONE. The minimum issue interval is therefore N+2 cycles.
REQ-014 All state and outputs SHALL be registered; no combinational path SHALL exist from inputs to outputs.

Reset
REQ-015 When `Reset`=0 on an edge, the block SHALL set:
- state = IDLE;
- `Result`=32'h00000000;
- count = 0;
- op register = 00;
- `Ready`=1, `Busy`=0, `Done`=0.
REQ-016 Reset SHALL take priority over `Start` and over any in-progress shift. An aborted operation SHALL produce no `Done` pulse.
REQ-017 In the first edge after `Reset` returns to 1, the block SHALL accept `Start` normally.

Verification
REQ-018 SLL basic: `Data`=0x00000001, `ShAmt`=4, `Op`=00 -> `Busy` high 4 cycles; `Done` on the 5th edge after `Start`; `Result`=0x00000010.
REQ-019 SRA vs SRL at maximum amount, `Data`=0x80000000, `ShAmt`=31:
- SRA -> `Result`=0xFFFFFFFF, `Done` at cycle 32.
- SRL -> `Result`=0x00000001.
REQ-020 Zero amount and upper-bit masking:
- `ShAmt`=0, `Data`=0xDEADBEEF -> `Done` at cycle 1, `Result`=0xDEADBEEF, `Busy` never asserted.
- `ShAmt`=0xFFFFFFE3 -> treated as 3.
REQ-021 ROTR: `Data`=0x00000001, `ShAmt`=1, `Op`=11 -> `Result`=0x80000000, `Done` at cycle 2.
REQ-022 Ignored inputs: toggle `Start`, `Data` and `Op` during SHIFT -> result unchanged from the captured operation; only one `Done` pulse; a back-to-back `Start` held high is accepted in the IDLE cycle after DONE.
REQ-023 Reset mid-shift: assert `Reset`=0 in the 2nd SHIFT cycle of a 10-bit shift -> next cycle `Ready`=1, `Result`=0, no `Done` pulse; a following `Start` completes correctly.
